// File: rtl/dma_ch_sched.sv
// rtl/dma_ch_sched.sv - round-robin DMA channel scheduler onto one AXI command port
module dma_ch_sched #(
   parameter int NUM_CH   = 4,
   parameter int MAX_OUTS = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         ch_en,
   input  logic [NUM_CH-1:0]         ch_req,
   input  logic [NUM_CH-1:0]         periph_sel,
   input  logic [NUM_CH-1:0]         periph_req,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic [$clog2(NUM_CH)-1:0] cmd_ch,
   output logic [NUM_CH-1:0]         ch_gnt,
   input  logic                      done_valid,
   input  logic [$clog2(NUM_CH)-1:0] done_ch,
   output logic [NUM_CH-1:0]         periph_clr,
   output logic [NUM_CH-1:0]         busy,
   output logic                      idle,
   output logic                      proto_err
);

   localparam int CW = $clog2(NUM_CH);
   localparam int NW = $clog2(MAX_OUTS + 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   logic [0:0]        state;
   logic              arb_en;
   logic [CW-1:0]     last_gnt;
   logic [NW-1:0]     outs_cnt;

   logic [NUM_CH-1:0] elig;
   logic              win_found;
   logic [CW-1:0]     win_ch;
   logic              accept;
   logic              can_issue;
   logic [NUM_CH-1:0] gnt_oh;
   logic [NUM_CH-1:0] done_oh;
   logic              done_hit;
   logic              done_ok;
   logic              done_bad;

   // A channel may compete only when enabled, requesting, not already in flight,
   // and (if peripheral-paced) its peripheral is ready.
   assign elig   = ch_en & ch_req & ~busy & (~periph_sel | periph_req);
   assign accept = cmd_valid & cmd_ready;

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      win_found = 1'b0;
      win_ch    = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         int idx;
         idx = (int'(last_gnt) + k) % NUM_CH;
         if (!win_found && elig[idx]) begin
            win_found = 1'b1;
            win_ch    = CW'(idx);
         end
      end
   end

   // Decode grant and completion channels; a completion is only legal for a busy
   // channel, and an out-of-range index never matches any channel.
   always_comb begin
      gnt_oh   = '0;
      done_oh  = '0;
      done_hit = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (accept && (cmd_ch == CW'(i))) begin
            gnt_oh[i] = 1'b1;
         end
         if (done_ch == CW'(i)) begin
            done_oh[i] = 1'b1;
            done_hit   = busy[i];
         end
      end
   end

   assign done_ok   = done_valid & done_hit;
   assign done_bad  = done_valid & ~done_hit;
   assign can_issue = (state == S_IDLE) & arb_en & win_found &
                      (outs_cnt < NW'(MAX_OUTS));

   assign ch_gnt = gnt_oh;
   assign idle   = (outs_cnt == '0) & ~cmd_valid & (state == S_IDLE);

   // Arbitration is held off for the first edge after reset so the first
   // winner is registered on the second edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         arb_en <= 1'b0;
      end else begin
         arb_en <= 1'b1;
      end
   end

   // Issue FSM: register the winner, hold it unchanged until accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         cmd_valid <= 1'b0;
         cmd_ch    <= '0;
         last_gnt  <= CW'(NUM_CH - 1);
      end else begin
         case (state)
            S_IDLE: begin
               if (can_issue) begin
                  state     <= S_ISSUE;
                  cmd_valid <= 1'b1;
                  cmd_ch    <= win_ch;
               end
            end
            S_ISSUE: begin
               if (cmd_ready) begin
                  state     <= S_IDLE;
                  cmd_valid <= 1'b0;
                  last_gnt  <= cmd_ch;
               end
            end
            default: begin
               state     <= S_IDLE;
               cmd_valid <= 1'b0;
            end
         endcase
      end
   end

   // Outstanding-burst bookkeeping: per-channel busy plus the shared count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy     <= '0;
         outs_cnt <= '0;
      end else begin
         busy <= (busy & ~(done_ok ? done_oh : '0)) | gnt_oh;
         case ({accept, done_ok})
            2'b10:   outs_cnt <= outs_cnt + 1'b1;
            2'b01:   outs_cnt <= outs_cnt - 1'b1;
            default: outs_cnt <= outs_cnt;
         endcase
      end
   end

   // Completion side effects: peripheral request clear pulse and sticky error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         periph_clr <= '0;
         proto_err  <= 1'b0;
      end else begin
         periph_clr <= done_ok ? (done_oh & periph_sel) : '0;
         if (done_bad) begin
            proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dma_ch_sched.sv
// tb/tb_dma_ch_sched.sv - directed vector bench for dma_ch_sched
module tb_dma_ch_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] ch_en = '0;
   logic [3:0] ch_req = '0;
   logic [3:0] periph_sel = '0;
   logic [3:0] periph_req = '0;
   logic       cmd_ready = 1'b0;
   logic       done_valid = 1'b0;
   logic [1:0] done_ch = '0;
   logic       cmd_valid;
   logic [1:0] cmd_ch;
   logic [3:0] ch_gnt;
   logic [3:0] periph_clr;
   logic [3:0] busy;
   logic       idle;
   logic       proto_err;

   int n_chk  = 0;
   int n_fail = 0;
   int max_cnt = 0;
   int max_busy = 0;

   dma_ch_sched #(.NUM_CH(4), .MAX_OUTS(2)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .ch_en      (ch_en),
      .ch_req     (ch_req),
      .periph_sel (periph_sel),
      .periph_req (periph_req),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_ch     (cmd_ch),
      .ch_gnt     (ch_gnt),
      .done_valid (done_valid),
      .done_ch    (done_ch),
      .periph_clr (periph_clr),
      .busy       (busy),
      .idle       (idle),
      .proto_err  (proto_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] en, req, psel, preq;
      logic       rdy, dv;
      logic [1:0] dch;
      logic       cv;
      logic [1:0] cch;
      logic [3:0] gnt, bsy, pclr;
      logic       idl, perr;
   } vec_t;

   vec_t tv[$];

   // Track peak occupancy across the whole run.
   always @(negedge clk) begin
      if (int'(dut.outs_cnt) > max_cnt) max_cnt = int'(dut.outs_cnt);
      if ($countones(busy) > max_busy) max_busy = $countones(busy);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic v(input logic [3:0] en, req, psel, preq, input logic rdy, dv,
                    input logic [1:0] dch, input logic cv, input logic [1:0] cch,
                    input logic [3:0] gnt, bsy, pclr, input logic idl, perr);
      vec_t r;
      r.en = en; r.req = req; r.psel = psel; r.preq = preq;
      r.rdy = rdy; r.dv = dv; r.dch = dch;
      r.cv = cv; r.cch = cch; r.gnt = gnt; r.bsy = bsy; r.pclr = pclr;
      r.idl = idl; r.perr = perr;
      tv.push_back(r);
   endtask

   task automatic wait_gnt(input logic [3:0] exp, input string nm);
      int n = 0;
      @(negedge clk);
      while (ch_gnt == 4'h0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(ch_gnt), 32'(exp));
   endtask

   initial begin
      logic [16:0] act, exp;
      int n;

      // en   req  psel preq rdy dv dch | cv cch gnt  busy pclr idle perr
      // full round robin with done returned four cycles after each grant
      v(4'hF,4'hF,4'h0,4'h0,1,0,0, 0,0,4'h0,4'h0,4'h0,1,0);
      v(4'hF,4'hF,4'h0,4'h0,1,0,0, 1,0,4'h1,4'h0,4'h0,0,0);
      v(4'hF,4'hF,4'h0,4'h0,1,0,0, 0,0,4'h0,4'h1,4'h0,0,0);
      v(4'hF,4'hF,4'h0,4'h0,1,0,0, 1,1,4'h2,4'h1,4'h0,0,0);
      v(4'hF,4'hF,4'h0,4'h0,1,0,0, 0,1,4'h0,4'h3,4'h0,0,0);
      v(4'hF,4'hF,4'h0,4'h0,1,1,0, 0,1,4'h0,4'h3,4'h0,0,0);
      v(4'hF,4'hF,4'h0,4'h0,1,0,0, 0,1,4'h0,4'h2,4'h0,0,0);
      v(4'hF,4'hF,4'h0,4'h0,1,1,1, 1,2,4'h4,4'h2,4'h0,0,0);
      v(4'hF,4'hF,4'h0,4'h0,1,0,0, 0,2,4'h0,4'h4,4'h0,0,0);
      v(4'hF,4'hF,4'h0,4'h0,1,0,0, 1,3,4'h8,4'h4,4'h0,0,0);
      v(4'hF,4'hF,4'h0,4'h0,1,0,0, 0,3,4'h0,4'hC,4'h0,0,0);
      v(4'hF,4'hF,4'h0,4'h0,1,1,2, 0,3,4'h0,4'hC,4'h0,0,0);
      v(4'hF,4'hF,4'h0,4'h0,1,0,0, 0,3,4'h0,4'h8,4'h0,0,0);
      v(4'hF,4'hF,4'h0,4'h0,1,1,3, 1,0,4'h1,4'h8,4'h0,0,0);
      v(4'hF,4'h0,4'h0,4'h0,0,0,0, 0,0,4'h0,4'h1,4'h0,0,0);
      v(4'hF,4'h0,4'h0,4'h0,0,1,0, 0,0,4'h0,4'h1,4'h0,0,0);
      v(4'h0,4'h0,4'h0,4'h0,0,0,0, 0,0,4'h0,4'h0,4'h0,1,0);
      // single request with cmd_ready held low; no withdrawal when req drops
      v(4'hF,4'h1,4'h0,4'h0,0,0,0, 0,0,4'h0,4'h0,4'h0,1,0);
      v(4'hF,4'h1,4'h0,4'h0,0,0,0, 1,0,4'h0,4'h0,4'h0,0,0);
      v(4'hF,4'h1,4'h0,4'h0,0,0,0, 1,0,4'h0,4'h0,4'h0,0,0);
      v(4'h0,4'h0,4'h0,4'h0,0,0,0, 1,0,4'h0,4'h0,4'h0,0,0);
      v(4'h0,4'h0,4'h0,4'h0,0,0,0, 1,0,4'h0,4'h0,4'h0,0,0);
      v(4'h0,4'h0,4'h0,4'h0,0,0,0, 1,0,4'h0,4'h0,4'h0,0,0);
      v(4'h0,4'h0,4'h0,4'h0,1,0,0, 1,0,4'h1,4'h0,4'h0,0,0);
      v(4'h0,4'h0,4'h0,4'h0,0,0,0, 0,0,4'h0,4'h1,4'h0,0,0);
      v(4'h0,4'h0,4'h0,4'h0,0,1,0, 0,0,4'h0,4'h1,4'h0,0,0);
      v(4'h0,4'h0,4'h0,4'h0,0,0,0, 0,0,4'h0,4'h0,4'h0,1,0);
      // peripheral-paced channel 2
      v(4'hF,4'h4,4'h4,4'h0,1,0,0, 0,0,4'h0,4'h0,4'h0,1,0);
      v(4'hF,4'h4,4'h4,4'h0,1,0,0, 0,0,4'h0,4'h0,4'h0,1,0);
      v(4'hF,4'h4,4'h4,4'h4,1,0,0, 0,0,4'h0,4'h0,4'h0,1,0);
      v(4'hF,4'h4,4'h4,4'h4,1,0,0, 1,2,4'h4,4'h0,4'h0,0,0);
      v(4'hF,4'h0,4'h4,4'h0,1,0,0, 0,2,4'h0,4'h4,4'h0,0,0);
      v(4'hF,4'h0,4'h4,4'h0,1,1,2, 0,2,4'h0,4'h4,4'h0,0,0);
      v(4'hF,4'h0,4'h4,4'h0,1,0,0, 0,2,4'h0,4'h0,4'h4,1,0);
      v(4'hF,4'h0,4'h4,4'h0,1,0,0, 0,2,4'h0,4'h0,4'h0,1,0);
      // completion for an idle channel
      v(4'h0,4'h0,4'h0,4'h0,0,1,3, 0,2,4'h0,4'h0,4'h0,1,0);
      v(4'h0,4'h0,4'h0,4'h0,0,0,0, 0,2,4'h0,4'h0,4'h0,1,1);
      v(4'h0,4'h0,4'h0,4'h0,0,0,0, 0,2,4'h0,4'h0,4'h0,1,1);

      // reset values while held in reset
      repeat (3) @(negedge clk);
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_cmd_ch", 32'(cmd_ch), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_proto_err", 32'(proto_err), 32'd0);
      chk("rst_periph_clr", 32'(periph_clr), 32'd0);
      rst_n = 1'b1;

      foreach (tv[i]) begin
         @(posedge clk);
         #1;
         ch_en = tv[i].en; ch_req = tv[i].req;
         periph_sel = tv[i].psel; periph_req = tv[i].preq;
         cmd_ready = tv[i].rdy; done_valid = tv[i].dv; done_ch = tv[i].dch;
         @(negedge clk);
         act = {cmd_valid, cmd_ch, ch_gnt, busy, periph_clr, idle, proto_err};
         exp = {tv[i].cv, tv[i].cch, tv[i].gnt, tv[i].bsy, tv[i].pclr, tv[i].idl, tv[i].perr};
         n_chk++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL row%0d: got cv=%b ch=%0d gnt=%b busy=%b pclr=%b idle=%b perr=%b, expected cv=%b ch=%0d gnt=%b busy=%b pclr=%b idle=%b perr=%b",
                     i, cmd_valid, cmd_ch, ch_gnt, busy, periph_clr, idle, proto_err,
                     tv[i].cv, tv[i].cch, tv[i].gnt, tv[i].bsy, tv[i].pclr, tv[i].idl, tv[i].perr);
         end
      end

      // outstanding limit: channels 0 and 1 busy block channel 3 until a done
      @(posedge clk);
      #1;
      ch_en = 4'hF; ch_req = 4'h3; periph_sel = 4'h0; periph_req = 4'h0;
      cmd_ready = 1'b1; done_valid = 1'b0;
      wait_gnt(4'h1, "lim_gnt0");
      wait_gnt(4'h2, "lim_gnt1");
      @(posedge clk);
      #1;
      ch_req = 4'h8;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("lim_stall_cmd_valid", 32'(cmd_valid), 32'd0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("lim_busy", 32'(busy), 32'h3);
      chk("lim_outs_cnt", 32'(dut.outs_cnt), 32'd2);
      @(posedge clk);
      #1;
      done_valid = 1'b1; done_ch = 2'd0;
      @(posedge clk);
      #1;
      done_valid = 1'b0;
      wait_gnt(4'h8, "lim_gnt3");
      @(posedge clk);
      #1;
      ch_req = 4'h0; done_valid = 1'b1; done_ch = 2'd1;
      @(posedge clk);
      #1;
      done_ch = 2'd3;
      @(posedge clk);
      #1;
      done_valid = 1'b0;
      ch_req = 4'h3;
      @(negedge clk);
      chk("drain_busy", 32'(busy), 32'h0);

      // reset while a command is offered and a burst is outstanding
      wait_gnt(4'h1, "pre_rst_gnt0");
      @(posedge clk);
      #1;
      cmd_ready = 1'b0;
      n = 0;
      @(negedge clk);
      while (!cmd_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("pre_rst_cmd_valid", 32'(cmd_valid), 32'd1);
      chk("pre_rst_cmd_ch", 32'(cmd_ch), 32'd1);
      chk("pre_rst_busy", 32'(busy), 32'h1);
      chk("pre_rst_proto_err", 32'(proto_err), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      ch_req = 4'hF; cmd_ready = 1'b1;
      #1;
      chk("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("mid_rst_cmd_ch", 32'(cmd_ch), 32'd0);
      chk("mid_rst_gnt", 32'(ch_gnt), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_outs_cnt", 32'(dut.outs_cnt), 32'd0);
      chk("mid_rst_idle", 32'(idle), 32'd1);
      chk("mid_rst_proto_err", 32'(proto_err), 32'd0);
      @(negedge clk);
      chk("mid_rst_periph_clr", 32'(periph_clr), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_edge1_cmd_valid", 32'(cmd_valid), 32'd0);
      @(negedge clk);
      chk("post_rst_edge2_cmd_valid", 32'(cmd_valid), 32'd1);
      chk("post_rst_cmd_ch", 32'(cmd_ch), 32'd0);
      chk("post_rst_gnt", 32'(ch_gnt), 32'h1);

      chk("peak_outs_cnt", 32'(max_cnt), 32'd2);
      chk("peak_busy_bits", 32'(max_busy), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
